// File: rtl/pipelined_addsub_core.sv
// Pipelined add/subtract core: one BLOCK-bit carry slice per register stage, valid/ready handshake.
// Optional `ADDSUB_ZERO_FLAG_EN adds a registered zero flag built from per-slice zero tests.
module pipelined_addsub_core #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef ADDSUB_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic             ovf
);

  localparam int STAGES = WIDTH / BLOCK;

  if ((WIDTH % BLOCK) != 0 || STAGES < 1) begin : g_param_err
    $error("pipelined_addsub_core: WIDTH must be a non-zero multiple of BLOCK");
  end

  typedef logic [WIDTH-1:0] word_t;

  word_t             a_q   [STAGES];
  word_t             bp_q  [STAGES];
  word_t             res_q [STAGES];
  word_t             a_d   [STAGES];
  word_t             bp_d  [STAGES];
  word_t             res_d [STAGES];
  logic [BLOCK:0]    sl    [STAGES];
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] en;
  logic              ovf_q, ovf_d;
`ifdef ADDSUB_ZERO_FLAG_EN
  logic [STAGES-1:0] z_q, z_d;
`endif

  function automatic logic [BLOCK:0] slice_add(input logic [BLOCK-1:0] x,
                                               input logic [BLOCK-1:0] y,
                                               input logic             c);
    return {1'b0, x} + {1'b0, y} + {{BLOCK{1'b0}}, c};
  endfunction

  // Ready chain runs back from the output; it never depends on in_valid.
  always_comb begin
    en = '0;
    en[STAGES-1] = !vld_q[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      en[k] = !vld_q[k] || en[k+1];
    end
  end

  assign in_ready = en[0];

  // Slice arithmetic feeding each stage register
  always_comb begin
    vld_d[0] = in_valid;
    a_d[0]   = a;
    bp_d[0]  = op ? ~b : b;
    res_d[0] = '0;
    sl[0]    = slice_add(a[BLOCK-1:0], bp_d[0][BLOCK-1:0], op ? ~cin : cin);
    for (int k = 1; k < STAGES; k++) begin
      vld_d[k] = vld_q[k-1];
      a_d[k]   = a_q[k-1];
      bp_d[k]  = bp_q[k-1];
      res_d[k] = res_q[k-1];
      sl[k]    = slice_add(a_q[k-1][k*BLOCK +: BLOCK], bp_q[k-1][k*BLOCK +: BLOCK], c_q[k-1]);
    end
    c_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      res_d[k][k*BLOCK +: BLOCK] = sl[k][BLOCK-1:0];
      c_d[k] = sl[k][BLOCK];
    end
    ovf_d = (a_d[STAGES-1][WIDTH-1] == bp_d[STAGES-1][WIDTH-1]) &&
            (res_d[STAGES-1][WIDTH-1] != a_d[STAGES-1][WIDTH-1]);
  end

`ifdef ADDSUB_ZERO_FLAG_EN
  always_comb begin
    z_d = '0;
    z_d[0] = ~|sl[0][BLOCK-1:0];
    for (int k = 1; k < STAGES; k++) begin
      z_d[k] = z_q[k-1] & ~|sl[k][BLOCK-1:0];
    end
  end
`endif

  // Stage registers; data only captured when a valid transaction moves in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
`ifdef ADDSUB_ZERO_FLAG_EN
      z_q   <= '0;
`endif
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        bp_q[k]  <= '0;
        res_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (en[k]) begin
          vld_q[k] <= vld_d[k];
          if (vld_d[k]) begin
            a_q[k]   <= a_d[k];
            bp_q[k]  <= bp_d[k];
            res_q[k] <= res_d[k];
            c_q[k]   <= c_d[k];
`ifdef ADDSUB_ZERO_FLAG_EN
            z_q[k]   <= z_d[k];
`endif
          end
        end
      end
      if (en[STAGES-1] && vld_d[STAGES-1]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = res_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;
`ifdef ADDSUB_ZERO_FLAG_EN
  assign zero      = z_q[STAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_addsub_core.sv
// Scoreboard bench for pipelined_addsub_core at WIDTH=32, BLOCK=8 (4 stages).
module tb_pipelined_addsub_core;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         op = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int tests = 0;
  int fails = 0;

  // entry layout: {cout, ovf, sum}
  logic [W+1:0] sb[$];

  pipelined_addsub_core #(.WIDTH(32), .BLOCK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic opv, input logic [W-1:0] av,
                                         input logic [W-1:0] bv, input logic c);
    logic [W-1:0] bp;
    logic         ci;
    logic [W:0]   t;
    logic         o;
    bp = opv ? ~bv : bv;
    ci = opv ? ~c : c;
    t  = {1'b0, av} + {1'b0, bp} + {{W{1'b0}}, ci};
    o  = (av[W-1] == bp[W-1]) && (t[W-1] != av[W-1]);
    return {t[W], o, t[W-1:0]};
  endfunction

  // Monitor: pops on every output transfer
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {32'h0, sum}, 64'hDEAD);
      end else begin
        logic [W+1:0] e;
        e = sb.pop_front();
        chk("sum", {32'h0, sum}, {32'h0, e[W-1:0]});
        chk("cout", {63'h0, cout}, {63'h0, e[W+1]});
        chk("ovf", {63'h0, ovf}, {63'h0, e[W]});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Drive one transaction; push expectation at the negedge before its accepting edge
  task automatic send(input logic opv, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic c, input logic [W+1:0] exp);
    bit done;
    done = 0;
    in_valid = 1'b1; op = opv; a = av; b = bv; cin = c;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(exp);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) @(posedge clk);
    #1;
  endtask

  logic [W-1:0] va[10];
  logic [W-1:0] vb[10];
  logic         vc[10];

  initial begin
    logic [W-1:0] held;
    bit           seen_full;
    int           idx;
    int           accepted;
    int           guard;

    // Reset then idle
    rst = 1'b1; #12; rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
    chk("rst_sum", {32'h0, sum}, 64'd0);
    chk("rst_cout_ovf", {62'h0, cout, ovf}, 64'd0);
    chk("rst_in_ready", {63'h0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Latency: visible after the 4th edge counting the accepting edge
    out_ready = 1'b1;
    send(1'b0, 32'h0, 32'h0, 1'b0, {1'b0, 1'b0, 32'h0000_0000});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("latency_c%0d", i), {63'h0, out_valid}, (i == 3) ? 64'd1 : 64'd0);
    end
    @(posedge clk); #1;

    // Carry ripple and subtract/overflow vectors
    send(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, {1'b1, 1'b0, 32'h0000_0000});
    send(1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, {1'b0, 1'b0, 32'h0001_0000});
    send(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, {1'b1, 1'b1, 32'h7FFF_FFFF});
    send(1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, {1'b0, 1'b0, 32'hFFFF_FFFF});
    send(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {1'b0, 1'b1, 32'h8000_0000});
    send(1'b1, 32'h0000_0005, 32'h0000_0003, 1'b1, {1'b1, 1'b0, 32'h0000_0001});
    drain(20);
    chk("directed_drained", sb.size(), 64'd0);

    // Backpressure: 10 back-to-back adds with consumer stalled
    for (int i = 0; i < 10; i++) begin
      va[i] = $urandom; vb[i] = $urandom; vc[i] = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b0;
    idx = 0; seen_full = 0; held = '0;
    in_valid = 1'b1; op = 1'b0; a = va[0]; b = vb[0]; cin = vc[0];
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(1'b0, va[idx], vb[idx], vc[idx]));
        idx++;
      end else if (!seen_full) begin
        seen_full = 1;
        chk("accepted_before_full", idx, 64'd4);
        held = sum;
      end else begin
        chk("stall_out_valid", {63'h0, out_valid}, 64'd1);
        chk("stall_sum_stable", {32'h0, sum}, {32'h0, held});
      end
      @(posedge clk); #1;
      if (idx < 10) begin a = va[idx]; b = vb[idx]; cin = vc[idx]; end
      else in_valid = 1'b0;
    end
    chk("full_seen", {63'h0, seen_full}, 64'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("stream_valid_c%0d", c), {63'h0, out_valid}, 64'd1);
      if (in_ready && idx < 10) begin
        sb.push_back(model(1'b0, va[idx], vb[idx], vc[idx]));
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 10) begin a = va[idx]; b = vb[idx]; cin = vc[idx]; end
      else in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("stream_all_sent", idx, 64'd10);
    drain(20);
    chk("stream_drained", sb.size(), 64'd0);

    // Bubble collapse
    out_ready = 1'b0;
    send(1'b0, 32'h0000_0010, 32'h0000_0020, 1'b0, {1'b0, 1'b0, 32'h0000_0030});
    @(posedge clk); #1;
    @(posedge clk); #1;
    send(1'b1, 32'h0000_0100, 32'h0000_0001, 1'b0, {1'b1, 1'b0, 32'h0000_00FF});
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    chk("bubble_in_ready", {63'h0, in_ready}, 64'd1);
    chk("bubble_head_valid", {63'h0, out_valid}, 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bubble_t0_valid", {63'h0, out_valid}, 64'd1);
    @(negedge clk);
    chk("bubble_t1_next", {63'h0, out_valid}, 64'd1);
    @(negedge clk);
    chk("bubble_then_empty", {63'h0, out_valid}, 64'd0);
    chk("bubble_drained", sb.size(), 64'd0);
    @(posedge clk); #1;

    // Reset mid-flight
    out_ready = 1'b0;
    send(1'b0, 32'h1, 32'h2, 1'b0, {1'b0, 1'b0, 32'h3});
    send(1'b0, 32'h4, 32'h5, 1'b0, {1'b0, 1'b0, 32'h9});
    send(1'b0, 32'h6, 32'h7, 1'b0, {1'b0, 1'b0, 32'hD});
    @(posedge clk); #1;
    chk("pre_rst_valid", {63'h0, out_valid}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", {63'h0, out_valid}, 64'd0);
    chk("async_rst_sum", {32'h0, sum}, 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_quiet_c%0d", c), {63'h0, out_valid}, 64'd0);
    end
    @(posedge clk); #1;

    // Random add/sub with random backpressure
    accepted = 0; guard = 0;
    while (accepted < 2000 && guard < 20000) begin
      guard++;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb.push_back(model(op, a, b, cin));
        accepted++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("random_accepted", accepted, 64'd2000);
    drain(50);
    chk("random_sb_empty", sb.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub_core.md
Name: pipelined_addsub_core

Overview:
Next-generation pipelined integer add/subtract core. It replaces the valid-only adder core with a valid/ready (backpressure) interface, a per-transaction add/sub mode, carry-out and signed-overflow outputs, and an asynchronous reset. The carry ripples through WIDTH/BLOCK register stages, one BLOCK-bit slice per stage. It sits between ALU operand muxes and the writeback stage, and allows a stalled consumer.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of BLOCK, otherwise elaboration fails.
BLOCK, 4, bits resolved per pipeline stage; STAGES = WIDTH/BLOCK, which must be >= 1.

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand transaction present.
in_ready  output  1  core accepts a transaction this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in (add) / borrow-in (sub).
op  input  1  0 = add, 1 = subtract.
out_valid  output  1  result present.
out_ready  input  1  consumer accepts result this cycle.
sum  output  WIDTH  result.
cout  output  1  carry-out (add) / NOT-borrow (sub).
ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (async assert, sync release): all stage valid bits = 0.
  - Outputs after reset: out_valid = 0, sum = 0, cout = 0, ovf = 0, in_ready = 1.
  - Reset mid-operation discards all in-flight transactions. No output follows for them.
- Arithmetic, per transaction:
  - add: {cout, sum} = a + b + cin.
  - sub: {cout, sum} = a + ~b + ~cin, i.e. a - b - cin. cout = 1 means no borrow.
  - ovf = (A_msb == B'_msb) && (sum_msb != A_msb), where B' = b for add and ~b for sub.
  - All results are modulo 2^WIDTH.
- Pipeline:
  - Stage k (1..STAGES) registers result bits [k*BLOCK-1 : (k-1)*BLOCK].
  - It also registers the carry into the next slice, plus the still-unprocessed upper slices of a, B', and op.
  - Carry never crosses a register boundary combinationally beyond one slice.
- Handshake:
  - Transfer in occurs when in_valid && in_ready at a rising edge. Transfer out occurs when out_valid && out_ready.
  - Inputs are don't-care when in_valid = 0.
  - The final stage may advance when it is empty, or out_ready = 1.
  - Stage k < STAGES advances when stage k+1 is empty or advancing.
  - in_ready = stage 1 empty or advancing. This is a combinational ready chain; there is no combinational path from in_valid to in_ready.
  - Bubbles collapse: an empty stage is filled even while later stages are stalled.
- Latency:
  - A transaction accepted at edge E presents out_valid = 1 in the cycle after edge E+STAGES-1, if never stalled.
  - Throughput is 1 transaction per clock while out_ready = 1.
- Stall behaviour:
  - While out_valid && !out_ready: sum, cout and ovf hold stable.
  - The pipeline absorbs up to STAGES transactions total, after which in_ready = 0.
- Ordering: results emerge strictly in acceptance order. No drop, no duplication.
- Simultaneous events: out transfer and in transfer in the same cycle are both honoured when the pipe is full (in_ready = 1 via the advancing chain).
- Boundary conditions:
  - STAGES = 1 gives a single registered full-width adder.
  - WIDTH = BLOCK is legal.

Optional Feature:
ADDSUB_ZERO_FLAG_EN
- Defined: adds output port zero (1 bit). zero = 1 iff sum == 0. It is registered and stalls with the other outputs, and resets to 0. The zero test is computed per slice and ANDed along the pipeline, with no full-width compare at the output.
- Undefined: no zero port exists, and no associated logic is generated.

Test Plan (WIDTH=32, BLOCK=8, STAGES=4):
- Reset then idle: rst pulse -> out_valid=0, sum=0, in_ready=1. Drive one add a=0, b=0, cin=0 -> out_valid exactly 4 cycles after acceptance edge, sum=0, cout=0, ovf=0.
- Carry ripple across all slices: add a=FFFFFFFF, b=0, cin=1 -> sum=00000000, cout=1, ovf=0. Then a=0000FFFF, b=1 -> sum=00010000.
- Subtract/overflow: sub a=80000000, b=1, cin=0 -> sum=7FFFFFFF, cout=1, ovf=1. Then sub a=0, b=1, cin=0 -> sum=FFFFFFFF, cout=0, ovf=0.
- Backpressure: stream 10 back-to-back random adds with out_ready=0 -> in_ready drops after exactly 4 accepted, outputs held stable. Release out_ready -> all 10 results in order, 1/cycle, checked against a scoreboard.
- Bubble collapse: accept T0, leave in_valid=0 for 2 cycles, accept T1, hold out_ready=0 -> T1 advances into the empty stages behind T0. After release, T1 follows T0 on the next cycle.
- Reset mid-flight: 3 transactions in pipe, assert rst asynchronously between edges -> out_valid falls immediately, no stale result appears after release. 2000 random add/sub vectors with random out_ready then pass with 0 errors and an empty scoreboard.
